// File: rtl/bbox_arbiter.sv
// Round-robin arbiter sharing one bbox unit between traversal lanes.
// Requests are tagged with the lane index; responses route back by tag.
package bbox_pkg;
  localparam int BBOX_REQ_WIDTH  = 32;
  localparam int BBOX_RESP_WIDTH = 32;
  localparam int RID_WIDTH       = 4;
endpackage

module bbox_arbiter
  import bbox_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int LIDX_W          = $clog2(N_REQ),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [N_REQ*BBOX_REQ_WIDTH-1:0]  lane_req_dat,
  input  logic [N_REQ-1:0]                 lane_req_vld,
  output logic [N_REQ-1:0]                 lane_req_rdy,
  output logic [BBOX_RESP_WIDTH-1:0]       lane_resp_dat,
  output logic [N_REQ-1:0]                 lane_resp_vld,
  input  logic [N_REQ-1:0]                 lane_resp_rdy,
  output logic [BBOX_REQ_WIDTH-1:0]        bbox_req_stream_rsc_dat,
  output logic                             bbox_req_stream_rsc_vld,
  input  logic                             bbox_req_stream_rsc_rdy,
  input  logic [BBOX_RESP_WIDTH-1:0]       bbox_resp_stream_rsc_dat,
  input  logic                             bbox_resp_stream_rsc_vld,
  output logic                             bbox_resp_stream_rsc_rdy,
  output logic [CNT_W-1:0]                 outstanding,
  output logic                             idle
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [BBOX_REQ_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                      out_vld_q, out_vld_d;
  logic [LIDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [LIDX_W-1:0] gnt_idx;
  logic [LIDX_W-1:0] cand;
  logic              gnt_found;
  logic              can_load;
  logic              load;
  logic [LIDX_W-1:0] rsp_idx;
  logic              ret;

  // First valid lane at or after rr_ptr; wrap is free since N_REQ is 2^k.
  always_comb begin
    gnt_idx   = rr_ptr_q;
    gnt_found = 1'b0;
    cand      = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_ptr_q + LIDX_W'(k);
      if (!gnt_found && lane_req_vld[cand]) begin
        gnt_idx   = cand;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    can_load = (!out_vld_q || bbox_req_stream_rsc_rdy)
            && (cnt_q < MAX_CNT);
    load     = can_load && gnt_found;
    lane_req_rdy          = '0;
    lane_req_rdy[gnt_idx] = can_load;
  end

  always_comb begin
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_dat_d = lane_req_dat[gnt_idx*BBOX_REQ_WIDTH +: BBOX_REQ_WIDTH];
      out_dat_d[LIDX_W-1:0] = gnt_idx;
      out_vld_d = 1'b1;
      rr_ptr_d  = gnt_idx + LIDX_W'(1);
    end else if (bbox_req_stream_rsc_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    rsp_idx = bbox_resp_stream_rsc_dat[LIDX_W-1:0];
    lane_resp_vld          = '0;
    lane_resp_vld[rsp_idx] = bbox_resp_stream_rsc_vld;
    bbox_resp_stream_rsc_rdy = lane_resp_rdy[rsp_idx];
    lane_resp_dat = bbox_resp_stream_rsc_dat;
    lane_resp_dat[LIDX_W-1:0] = '0;
    ret = bbox_resp_stream_rsc_vld && lane_resp_rdy[rsp_idx];
  end

  // A stray return at zero credit is dropped rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      load && !ret: cnt_d = cnt_q + CNT_W'(1);
      ret && !load && (cnt_q != '0): cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bbox_req_stream_rsc_dat = out_dat_q;
  assign bbox_req_stream_rsc_vld = out_vld_q;
  assign outstanding             = cnt_q;
  assign idle = (cnt_q == '0) && !out_vld_q;

endmodule
